// File: rtl/seg_scan_decoder.sv
// Seven-segment scan receiver: filters, decodes and frames scanned digits.
// Optional SEG_SCAN_DP_EN adds decimal-point capture (dp in, dp_out out).
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
`ifdef SEG_SCAN_DP_EN
  input  logic                  dp,
`endif
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     err,
  output logic                  frame_valid,
  output logic                  glitch
`ifdef SEG_SCAN_DP_EN
  ,
  output logic [DIGITS-1:0]     dp_out
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CPRE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CONE = CW'(1);

  logic [6:0]          s_seg;
  logic [DIGITS-1:0]   s_an;
  logic [CW-1:0]       cnt;
  logic [DIGITS-1:0]   seen;
  logic [4*DIGITS-1:0] sh_val;
  logic [DIGITS-1:0]   sh_blank;
  logic [DIGITS-1:0]   sh_err;

  logic [CW-1:0]       cnt_nx;
  logic [DIGITS-1:0]   sel;
  logic [DIGITS-1:0]   seen_nx;
  logic [4*DIGITS-1:0] val_nx;
  logic [DIGITS-1:0]   blank_nx;
  logic [DIGITS-1:0]   err_nx;
  logic [5:0]          dec;
  logic                onehot;
  logic                idle;
  logic                same;
  logic                cap;
  logic                done;
  int                  nlow;

`ifdef SEG_SCAN_DP_EN
  logic                s_dp;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   dp_nx;
`endif

  // Returns {err, blank, nibble}
  function automatic logic [5:0] decode(
    input logic [6:0] s
  );
    logic [5:0] r;
    case (s)
      7'b1000000: r = 6'h00;
      7'b1111001: r = 6'h01;
      7'b0100100: r = 6'h02;
      7'b0110000: r = 6'h03;
      7'b0011001: r = 6'h04;
      7'b0010010: r = 6'h05;
      7'b0000010: r = 6'h06;
      7'b1111000: r = 6'h07;
      7'b0000000: r = 6'h08;
      7'b0010000: r = 6'h09;
      7'b0001000: r = 6'h0a;
      7'b0000011: r = 6'h0b;
      7'b1000110: r = 6'h0c;
      7'b0100001: r = 6'h0d;
      7'b0000110: r = 6'h0e;
      7'b0001110: r = 6'h0f;
      7'b1111111: r = 6'h10;
      default:    r = 6'h20;
    endcase
    return r;
  endfunction

  always_comb begin
    nlow = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) nlow = nlow + 1;
    end
    sel    = ~an;
    onehot = (nlow == 1);
    idle   = &an;
`ifdef SEG_SCAN_DP_EN
    same   = ({seg, an, dp} == {s_seg, s_an, s_dp});
`else
    same   = ({seg, an} == {s_seg, s_an});
`endif
  end

  always_comb begin
    cnt_nx = '0;
    if (onehot && same) begin
      cnt_nx = (cnt == CMAX) ? cnt : cnt + CONE;
    end else if (onehot) begin
      cnt_nx = CONE;
    end
  end

  // A fresh sample can only capture when a single sample is enough
  assign cap = onehot &&
               (same ? (cnt == CPRE)
                     : (STABLE_CYCLES == 1));

  always_comb begin
    dec      = decode(seg);
    seen_nx  = cap ? (seen | sel) : seen;
    done     = cap && (&seen_nx);
    val_nx   = sh_val;
    blank_nx = sh_blank;
    err_nx   = sh_err;
`ifdef SEG_SCAN_DP_EN
    dp_nx    = sh_dp;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (cap && sel[i]) begin
        val_nx[4*i +: 4] = dec[3:0];
        blank_nx[i]      = dec[4];
        err_nx[i]        = dec[5];
`ifdef SEG_SCAN_DP_EN
        dp_nx[i]         = ~dp;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_seg       <= '0;
      s_an        <= '0;
      cnt         <= '0;
      seen        <= '0;
      sh_val      <= '0;
      sh_blank    <= '0;
      sh_err      <= '0;
      value       <= '0;
      blank       <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
      glitch      <= 1'b0;
`ifdef SEG_SCAN_DP_EN
      s_dp        <= 1'b0;
      sh_dp       <= '0;
      dp_out      <= '0;
`endif
    end else begin
      s_seg       <= seg;
      s_an        <= an;
      cnt         <= cnt_nx;
      sh_val      <= val_nx;
      sh_blank    <= blank_nx;
      sh_err      <= err_nx;
      seen        <= done ? '0 : seen_nx;
      frame_valid <= done;
      glitch      <= !onehot && !idle;
`ifdef SEG_SCAN_DP_EN
      s_dp        <= dp;
      sh_dp       <= dp_nx;
`endif
      if (done) begin
        value     <= val_nx;
        blank     <= blank_nx;
        err       <= err_nx;
`ifdef SEG_SCAN_DP_EN
        dp_out    <= dp_nx;
`endif
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive side of the multiplexed seven-segment display interface. Samples the active-low segment bus and active-low digit-enable (anode) lines that the display driver scans.
- Applies a per-dwell stability filter and decodes each segment pattern back to its hex nibble.
- Assembles a full multi-digit frame and presents it with a one-cycle valid strobe.
- Used for display loopback checking and board-level self-test.

Parameters:
- DIGITS, 4, number of scanned digits; an[0] selects digit 0, which is the least-significant nibble.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured; must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- seg  in  7  segment bus, active-low, bit0=a … bit6=g; synchronous to clk
- an  in  DIGITS  digit enables, active-low, synchronous to clk
- value  out  4*DIGITS  decoded frame; nibble i = digit i
- blank  out  DIGITS  digit i was all-segments-off (seg=7'b1111111)
- err  out  DIGITS  digit i pattern not in decode table
- frame_valid  out  1  one-cycle pulse; value/blank/err updated on the same edge
- glitch  out  1  one-cycle pulse for a sampled an that is neither one-hot-low nor all-ones

Behaviour:
- Reset: rst_n low at a clk edge clears all of the following to 0: outputs, the sample registers (s_seg, s_an), the stability counter cnt, the seen mask, and the shadow digit registers. Reset mid-frame discards all partial captures.
- Decode table (seg[6:0] → nibble):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
  - 1111111 → nibble 0, blank=1.
  - Any other pattern (including 0111111) → nibble 0, err=1.
- Stability filter, evaluated at each edge:
  - onehot = exactly one bit of an low.
  - If onehot and {seg,an}=={s_seg,s_an}, cnt ← min(cnt+1, STABLE_CYCLES).
  - Else if onehot, cnt ← 1. Else cnt ← 0.
  - Always {s_seg,s_an} ← {seg,an}.
- Capture:
  - Occurs on the edge where cnt transitions to STABLE_CYCLES.
  - Writes the decoded nibble/blank/err into shadow[i] for the active digit i and sets seen[i].
  - Saturation guarantees exactly one capture per dwell.
  - With STABLE_CYCLES=1, capture happens on the first edge at which a one-hot an is present, provided it differs from the previous sample.
- Recapture: capturing a digit already in seen overwrites shadow[i]; seen is unchanged.
- Frame completion:
  - On the capture edge that makes seen all-ones, value/blank/err ← shadow (including the digit captured this edge), frame_valid ← 1 for exactly one cycle, and seen ← 0.
  - Outputs hold between frames.
- an all-ones (blanking gap) → cnt=0, no capture, no glitch.
- Multi-hot an → cnt=0, no capture, glitch=1 for the cycle after the sample.
- Latency:
  - Capture occurs at the STABLE_CYCLES-th edge with inputs held.
  - frame_valid is visible in the cycle following the completing capture edge.
- Scan order is irrelevant; any order that covers all digits completes a frame.

Optional Feature:
- Macro: SEG_SCAN_DP_EN
- Defined: adds input dp (1 bit, active-low decimal point) and output dp_out [DIGITS-1:0].
  - dp is part of the stability comparison; a change in dp restarts cnt at 1.
  - dp_out[i] = ~dp at capture, committed with the frame.
- Undefined: no dp/dp_out ports; behaviour exactly as above.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with random seg/an → value=0, blank=0, err=0, frame_valid=0, glitch=0.
- Full frame (DIGITS=4, STABLE_CYCLES=4): dwell 4 cycles each on an=1110 seg=0100100, an=1101 seg=1111001, an=1011 seg=0001000, an=0111 seg=1000000 → single frame_valid pulse after the 16th edge, value=16'h0A12, blank=0, err=0.
- Short dwell: an=1101 held 3 cycles, then an=1111 → no capture, seen[1]=0. Repeat with a 4-cycle dwell → captured, and the frame completes after the remaining digits.
- Blank/invalid: digit2 seg=0111111, digit3 seg=1111111, digits 0/1 valid → err=4'b0100, blank=4'b1000, value[15:8]=8'h00.
- Glitch and reset: an=1100 for 10 cycles → glitch pulses, no capture. Capture digits 0,1, pulse rst_n low for one edge, then capture digits 2,3 → no frame_valid until all four digits are recaptured.
